// File: rtl/board_io_pkg.sv
// Shared constants for the board input conditioner.
//   DEF_N_KEY / DEF_N_SW : default push-button / slide-switch counts (DE1)
//   KEY_LSB, SW_LSB, KFLAG_LSB : field offsets inside the 32-bit PIO_IN word
//   GPIO_IN_RST : value of the PIO_IN word while/after reset (keys released)
package board_io_pkg;
  localparam int          DEF_N_KEY   = 4;
  localparam int          DEF_N_SW    = 10;
  localparam int          KEY_LSB     = 0;
  localparam int          SW_LSB      = 4;
  localparam int          KFLAG_LSB   = 14;
  localparam logic [31:0] GPIO_IN_RST = 32'h0000_000F;
endpackage

// File: rtl/debounce_bit.sv
// One conditioned input bit: 2-FF synchronizer then stable-count debouncer.
// A new level must be seen at the synchronizer output for DEBOUNCE_CYCLES
// consecutive clocks before it replaces the stable level; any return to the
// stable level restarts the count from zero.
//   clk_clk     : clock
//   reset_reset : synchronous active-high reset (sync + stable -> RST_VAL)
//   raw_i       : asynchronous raw pin
//   stable_o    : debounced level (registered)
//   accept_o    : high in the cycle stable_o is about to take the new level
module debounce_bit #(
  parameter int   DEBOUNCE_CYCLES = 500000,
  parameter logic RST_VAL         = 1'b0
) (
  input  logic clk_clk,
  input  logic reset_reset,
  input  logic raw_i,
  output logic stable_o,
  output logic accept_o
);
  localparam int             CW      = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          stable_q, stable_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          accept;

  always_comb begin
    sync1_d  = raw_i;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    cnt_d    = '0;
    accept   = 1'b0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_MAX) begin
        stable_d = sync2_q;
        accept   = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      sync1_q  <= RST_VAL;
      sync2_q  <= RST_VAL;
      stable_q <= RST_VAL;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable_o = stable_q;
  assign accept_o = accept;
endmodule

// File: rtl/board_input_conditioner.sv
// Conditions DE1 KEY (active-low) and SW pins into the PIO_IN word.
//   Word: [3:0] debounced KEY, [13:4] debounced SW,
//         [17:14] sticky KEY press flags (only with KEY_EDGE_CAPTURE_EN), rest 0.
// Optional feature macro: KEY_EDGE_CAPTURE_EN (press flags + edge_clr_i).
//   clk_clk     : CLOCK_50 domain clock
//   reset_reset : synchronous active-high reset
//   key_raw_i   : raw KEY pins, 0 = pressed
//   sw_raw_i    : raw SW pins
//   edge_clr_i  : per-key clear of press flags (unused without the macro)
//   gpio_in_o   : conditioned word, register-driven only
module board_input_conditioner
  import board_io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int N_KEY           = DEF_N_KEY,
  parameter int N_SW            = DEF_N_SW
) (
  input  logic             clk_clk,
  input  logic             reset_reset,
  input  logic [N_KEY-1:0] key_raw_i,
  input  logic [N_SW-1:0]  sw_raw_i,
  input  logic [N_KEY-1:0] edge_clr_i,
  output logic [31:0]      gpio_in_o
);
  logic [N_KEY-1:0] key_db, key_acc;
  logic [N_SW-1:0]  sw_db, sw_acc;
  logic [N_KEY-1:0] kflag;

  // Keys idle high (released), switches idle low.
  for (genvar i = 0; i < N_KEY; i++) begin : g_key
    debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RST_VAL(1'b1)) u_db (
      .clk_clk(clk_clk), .reset_reset(reset_reset), .raw_i(key_raw_i[i]),
      .stable_o(key_db[i]), .accept_o(key_acc[i]));
  end

  for (genvar i = 0; i < N_SW; i++) begin : g_sw
    debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RST_VAL(1'b0)) u_db (
      .clk_clk(clk_clk), .reset_reset(reset_reset), .raw_i(sw_raw_i[i]),
      .stable_o(sw_db[i]), .accept_o(sw_acc[i]));
  end

`ifdef KEY_EDGE_CAPTURE_EN
  logic [N_KEY-1:0] kflag_q, kflag_d;

  // A press is an accepted change while the stable level is still 1, so the
  // flag lands on the same edge the debounced key falls. Set beats clear.
  always_comb begin
    kflag_d = (kflag_q & ~edge_clr_i) | (key_acc & key_db);
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) kflag_q <= '0;
    else             kflag_q <= kflag_d;
  end

  assign kflag = kflag_q;
`else
  logic unused_clr;
  assign unused_clr = ^edge_clr_i;
  assign kflag      = '0;
`endif

  logic unused_acc;
  assign unused_acc = ^{sw_acc, key_acc};

  always_comb begin
    gpio_in_o                          = '0;
    gpio_in_o[KEY_LSB   +: N_KEY]      = key_db;
    gpio_in_o[SW_LSB    +: N_SW]       = sw_db;
    gpio_in_o[KFLAG_LSB +: N_KEY]      = kflag;
  end
endmodule
